// File: rtl/rv_pipe_pkg.sv
// Shared constants for the RV32 pipeline front end: default PC width,
// reset vector, sequential step and the layout of a fetch queue entry.
package rv_pipe_pkg;

  localparam int unsigned RV_XLEN     = 32;
  localparam int unsigned RV_RESET_PC = 0;
  localparam int unsigned RV_PC_STEP  = 4;

  // Queue entry layout, MSB to LSB: {instr, pc, fault}
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FAULT_W = 1;

  function automatic int unsigned entry_width(input int unsigned xlen);
    return INSTR_W + xlen + FAULT_W;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instruction entries. Flush empties the
// queue and takes priority over push and pop. Pointers wrap naturally
// because DEPTH is a power of two.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full queue may still accept a push
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage, pointers and occupancy; storage is cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: drives a one-cycle-latency IMEM port,
// queues returned words with their PCs and hands them to decode over a
// valid/ready handshake. A redirect from EX flushes everything queued or
// in flight and restarts fetch at the target.
module fetch_queue
  import rv_pipe_pkg::*;
#(
  parameter int unsigned       XLEN     = RV_XLEN,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RV_RESET_PC),
  parameter int unsigned       PC_STEP  = RV_PC_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic [INSTR_W-1:0]       imem_rdata_i,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [INSTR_W-1:0]       dec_instr_o,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic                     dec_fault_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = CW + 1;
  localparam int unsigned EW = entry_width(XLEN);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  logic            pop;
  logic            push;
  logic            issue_ok;
  logic [DW-1:0]   demand;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic [EW-1:0]   fifo_data;

  // Request, pop/push and next-state decisions; a redirect overrides the issue rule and drops the arriving response
  always_comb begin
    pop          = dec_valid_o & dec_ready_i & ~redirect_valid_i;
    demand       = DW'(fifo_count) + DW'(resp_valid_q) - DW'(pop);
    issue_ok     = (demand < DW'(DEPTH));
    imem_req_o   = rst_n & (redirect_valid_i | issue_ok);
    imem_addr_o  = redirect_valid_i ? redirect_pc_i : fetch_pc_q;
    fetch_pc_d   = imem_req_o ? (imem_addr_o + XLEN'(PC_STEP)) : fetch_pc_q;
    resp_valid_d = imem_req_o;
    resp_pc_d    = imem_addr_o;
    push         = resp_valid_q & ~redirect_valid_i & (~fifo_full | pop);
    fifo_data    = {imem_rdata_i, resp_pc_q, (resp_pc_q[1:0] != 2'b00)};
  end

  // Fetch PC and the one outstanding IMEM response tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .data_i  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign dec_valid_o = ~fifo_empty;
  assign count_o     = fifo_count;
  assign {dec_instr_o, dec_pc_o, dec_fault_o} = fifo_head;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected decode PCs are queued as each
// scenario is set up and a monitor checks every accepted instruction
// against them, while the main process checks requests, counts and resets.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata = 32'h0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        decValid;
  logic        decReady = 1'b0;
  logic [31:0] decInstr;
  logic [31:0] decPc;
  logic        decFault;
  logic [2:0]  count;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] expPcQ[$];
  logic [31:0] monExpPc;
  int          reqSeen;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_o       (imemReq),
    .imem_addr_o      (imemAddr),
    .imem_rdata_i     (imemRdata),
    .redirect_valid_i (redirectValid),
    .redirect_pc_i    (redirectPc),
    .dec_valid_o      (decValid),
    .dec_ready_i      (decReady),
    .dec_instr_o      (decInstr),
    .dec_pc_o         (decPc),
    .dec_fault_o      (decFault),
    .count_o          (count)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  // IMEM model: one-cycle read latency, garbage when not requested
  always @(posedge clk) begin
    imemRdata <= imemReq ? instrOf(imemAddr) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every accepted head must match the next expected PC
  always @(negedge clk) begin
    if (rst_n && decValid && decReady && !redirectValid) begin
      if (expPcQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected pop: got pc 0x%08h, expected no instruction", decPc);
      end else begin
        monExpPc = expPcQ.pop_front();
        checkOutput("pop pc", decPc, monExpPc);
        checkOutput("pop instr", decInstr, instrOf(monExpPc));
        checkOutput("pop fault", {31'b0, decFault}, {31'b0, (monExpPc[1:0] != 2'b00)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic ready);
    redirectValid = valid;
    redirectPc    = pc;
    decReady      = ready;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " imem_req"},  {31'b0, imemReq},  32'h0);
    checkOutput({tag, " dec_valid"}, {31'b0, decValid}, 32'h0);
    checkOutput({tag, " dec_instr"}, decInstr,          32'h0);
    checkOutput({tag, " dec_pc"},    decPc,             32'h0);
    checkOutput({tag, " dec_fault"}, {31'b0, decFault}, 32'h0);
    checkOutput({tag, " count"},     {29'b0, count},    32'h0);
  endtask

  // Asserts reset, checks the cleared outputs and releases at cycle 0
  task automatic resetDut(input logic ready);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, ready);
    #1;
    checkResetOutputs("reset");
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic endTest(input string tag);
    checkOutput({tag, " leftover expected"}, expPcQ.size(), 32'h0);
    expPcQ.delete();
  endtask

  initial begin
    // Steady streaming from reset
    resetDut(1'b1);
    for (int k = 0; k < 8; k++) expPcQ.push_back(32'(4 * k));
    for (int k = 0; k < 10; k++) begin
      atNeg();
      checkOutput("t1 imem_req", {31'b0, imemReq}, 32'h1);
      checkOutput("t1 imem_addr", imemAddr, 32'(4 * k));
      if (k < 2) checkOutput("t1 early dec_valid", {31'b0, decValid}, 32'h0);
      else       checkOutput("t1 steady count", {29'b0, count}, 32'h1);
      step();
    end
    endTest("t1");

    // Stall from reset until the queue fills, then drain
    resetDut(1'b0);
    for (int k = 0; k < 6; k++) expPcQ.push_back(32'(4 * k));
    reqSeen = 0;
    for (int k = 0; k < 8; k++) begin
      atNeg();
      if (imemReq) reqSeen++;
      checkOutput("t2 imem_req", {31'b0, imemReq}, {31'b0, (k < 4)});
      if (k < 4) checkOutput("t2 imem_addr", imemAddr, 32'(4 * k));
      if (k >= 2) begin
        checkOutput("t2 held dec_pc", decPc, 32'h0);
        checkOutput("t2 held dec_instr", decInstr, instrOf(32'h0));
      end
      step();
    end
    checkOutput("t2 full count", {29'b0, count}, 32'h4);
    checkOutput("t2 request total", reqSeen, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 8; k < 14; k++) begin
      atNeg();
      checkOutput("t2 drain dec_valid", {31'b0, decValid}, 32'h1);
      step();
    end
    endTest("t2");

    // Redirect with three queued entries and a response in flight
    resetDut(1'b0);
    for (int k = 0; k < 4; k++) step();
    checkOutput("t3 count before redirect", {29'b0, count}, 32'h3);
    applyStimulus(1'b1, 32'h100, 1'b0);
    for (int k = 0; k < 4; k++) expPcQ.push_back(32'h100 + 32'(4 * k));
    atNeg();
    checkOutput("t3 redirect imem_req", {31'b0, imemReq}, 32'h1);
    checkOutput("t3 redirect imem_addr", imemAddr, 32'h100);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3 count after flush", {29'b0, count}, 32'h0);
    atNeg();
    checkOutput("t3 dec_valid after flush", {31'b0, decValid}, 32'h0);
    checkOutput("t3 sequential imem_addr", imemAddr, 32'h104);
    step();
    for (int k = 6; k < 10; k++) begin
      atNeg();
      checkOutput("t3 dec_valid", {31'b0, decValid}, 32'h1);
      checkOutput("t3 count", {29'b0, count}, 32'h1);
      step();
    end
    endTest("t3");

    // Back-to-back redirects: only the latest target is presented
    resetDut(1'b1);
    expPcQ.push_back(32'h0);
    expPcQ.push_back(32'h4);
    for (int k = 0; k < 4; k++) step();
    applyStimulus(1'b1, 32'h200, 1'b1);
    step();
    applyStimulus(1'b1, 32'h300, 1'b1);
    checkOutput("t4 count after first flush", {29'b0, count}, 32'h0);
    for (int k = 0; k < 3; k++) expPcQ.push_back(32'h300 + 32'(4 * k));
    atNeg();
    checkOutput("t4 second redirect imem_addr", imemAddr, 32'h300);
    checkOutput("t4 dec_valid between", {31'b0, decValid}, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    atNeg();
    checkOutput("t4 dec_valid t+1", {31'b0, decValid}, 32'h0);
    step();
    for (int k = 7; k < 10; k++) begin
      atNeg();
      checkOutput("t4 dec_valid", {31'b0, decValid}, 32'h1);
      step();
    end
    endTest("t4");

    // Misaligned redirect target is fetched unmodified and tagged
    resetDut(1'b0);
    applyStimulus(1'b1, 32'h102, 1'b0);
    expPcQ.push_back(32'h102);
    expPcQ.push_back(32'h106);
    expPcQ.push_back(32'h10A);
    atNeg();
    checkOutput("t5 imem_addr", imemAddr, 32'h102);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    atNeg();
    checkOutput("t5 next imem_addr", imemAddr, 32'h106);
    step();
    atNeg();
    checkOutput("t5 dec_pc", decPc, 32'h102);
    checkOutput("t5 dec_fault", {31'b0, decFault}, 32'h1);
    step();
    for (int k = 3; k < 5; k++) begin
      atNeg();
      step();
    end
    endTest("t5");

    // PC wrap at the top of the address space, then async reset mid-stream
    resetDut(1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    expPcQ.push_back(32'hFFFF_FFF8);
    expPcQ.push_back(32'hFFFF_FFFC);
    expPcQ.push_back(32'h0000_0000);
    expPcQ.push_back(32'h0000_0004);
    atNeg();
    checkOutput("t6 imem_addr c0", imemAddr, 32'hFFFF_FFF8);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    atNeg();
    checkOutput("t6 imem_addr c1", imemAddr, 32'hFFFF_FFFC);
    step();
    atNeg();
    checkOutput("t6 wrapped imem_addr", imemAddr, 32'h0000_0000);
    step();
    atNeg();
    checkOutput("t6 imem_addr c3", imemAddr, 32'h0000_0004);
    step();
    atNeg();
    step();
    atNeg();
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    atNeg();
    step();
    checkOutput("t6 count before reset", {29'b0, count}, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("t6 async reset");
    endTest("t6");
    step();
    step();
    rst_n = 1'b1;
    atNeg();
    checkOutput("t6 first req after reset", {31'b0, imemReq}, 32'h1);
    checkOutput("t6 first addr after reset", imemAddr, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
